id_ex_alu_decode: RTL and testbench



---
 rtl/id_ex_alu_decode.sv | 142 ++++++++++++++
 tb/tb_id_ex_alu_decode.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/id_ex_alu_decode.sv
// ID/EX boundary: decodes a MIPS instruction into ALU controls and registers them,
// with hazard-unit stall (hold) and flush (bubble) controls.
module id_ex_alu_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstrD,
  input  logic        ValidD,
  input  logic        StallE,
  input  logic        FlushE,
  output logic [3:0]  ALUControlE,
  output logic        ALUSrcE,
  output logic        ShamtSelE,
  output logic [4:0]  ShamtE,
  output logic [31:0] ImmE,
  output logic        RegWriteE,
  output logic        RegDstE,
  output logic        ValidE,
  output logic        IllegalE
);

  localparam logic [3:0] ALU_ADDU = 4'b0000, ALU_ADD  = 4'b0001,
                         ALU_SUBU = 4'b0010, ALU_SUB  = 4'b0011,
                         ALU_SLTU = 4'b0100, ALU_SLT  = 4'b0101,
                         ALU_SLL  = 4'b0110, ALU_SLLV = 4'b0111,
                         ALU_SRL  = 4'b1000, ALU_SRLV = 4'b1001,
                         ALU_SRA  = 4'b1010, ALU_SRAV = 4'b1011,
                         ALU_AND  = 4'b1100, ALU_OR   = 4'b1101,
                         ALU_XOR  = 4'b1110, ALU_NOR  = 4'b1111;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;

  assign op       = InstrD[31:26];
  assign funct    = InstrD[5:0];
  assign imm_sext = {{16{InstrD[15]}}, InstrD[15:0]};
  assign imm_zext = {16'b0, InstrD[15:0]};

  logic [3:0]  alu_control_next;
  logic        alu_src_next;
  logic        shamt_sel_next;
  logic [4:0]  shamt_next;
  logic [31:0] imm_next;
  logic        reg_write_next;
  logic        reg_dst_next;
  logic        illegal_next;

  always_comb begin
    alu_control_next = ALU_ADDU;
    alu_src_next     = 1'b0;
    shamt_sel_next   = 1'b0;
    shamt_next       = 5'd0;
    imm_next         = 32'd0;
    reg_write_next   = 1'b0;
    reg_dst_next     = 1'b0;
    illegal_next     = 1'b0;

    case (op)
      6'h00: begin
        reg_dst_next   = 1'b1;
        reg_write_next = 1'b1;
        case (funct)
          6'h21: alu_control_next = ALU_ADDU;
          6'h20: alu_control_next = ALU_ADD;
          6'h23: alu_control_next = ALU_SUBU;
          6'h22: alu_control_next = ALU_SUB;
          6'h2B: alu_control_next = ALU_SLTU;
          6'h2A: alu_control_next = ALU_SLT;
          6'h04: alu_control_next = ALU_SLLV;
          6'h06: alu_control_next = ALU_SRLV;
          6'h07: alu_control_next = ALU_SRAV;
          6'h24: alu_control_next = ALU_AND;
          6'h25: alu_control_next = ALU_OR;
          6'h26: alu_control_next = ALU_XOR;
          6'h27: alu_control_next = ALU_NOR;
          6'h00, 6'h02, 6'h03: begin
            // Constant shifts feed the shamt field into the A operand.
            alu_control_next = (funct == 6'h00) ? ALU_SLL :
                               (funct == 6'h02) ? ALU_SRL : ALU_SRA;
            shamt_sel_next   = 1'b1;
            shamt_next       = InstrD[10:6];
          end
          default: begin
            illegal_next   = 1'b1;
            reg_dst_next   = 1'b0;
            reg_write_next = 1'b0;
          end
        endcase
      end
      6'h08: begin alu_control_next = ALU_ADD;  alu_src_next = 1'b1; imm_next = imm_sext; reg_write_next = 1'b1; end
      6'h09: begin alu_control_next = ALU_ADDU; alu_src_next = 1'b1; imm_next = imm_sext; reg_write_next = 1'b1; end
      6'h0A: begin alu_control_next = ALU_SLT;  alu_src_next = 1'b1; imm_next = imm_sext; reg_write_next = 1'b1; end
      6'h0B: begin alu_control_next = ALU_SLTU; alu_src_next = 1'b1; imm_next = imm_sext; reg_write_next = 1'b1; end
      6'h0C: begin alu_control_next = ALU_AND;  alu_src_next = 1'b1; imm_next = imm_zext; reg_write_next = 1'b1; end
      6'h0D: begin alu_control_next = ALU_OR;   alu_src_next = 1'b1; imm_next = imm_zext; reg_write_next = 1'b1; end
      6'h0E: begin alu_control_next = ALU_XOR;  alu_src_next = 1'b1; imm_next = imm_zext; reg_write_next = 1'b1; end
      6'h0F: begin
        // LUI is computed as imm << 16 on the ALU's shifter.
        alu_control_next = ALU_SLL;
        alu_src_next     = 1'b1;
        shamt_sel_next   = 1'b1;
        shamt_next       = 5'd16;
        imm_next         = imm_zext;
        reg_write_next   = 1'b1;
      end
      6'h23: begin alu_control_next = ALU_ADDU; alu_src_next = 1'b1; imm_next = imm_sext; reg_write_next = 1'b1; end
      6'h2B: begin alu_control_next = ALU_ADDU; alu_src_next = 1'b1; imm_next = imm_sext; end
      6'h04, 6'h05: begin
        // Branch compare uses rs - rt; the offset still travels in ImmE.
        alu_control_next = ALU_SUBU;
        imm_next         = imm_sext;
      end
      default: illegal_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || FlushE || (!StallE && !ValidD)) begin
      ALUControlE <= ALU_ADDU;
      ALUSrcE     <= 1'b0;
      ShamtSelE   <= 1'b0;
      ShamtE      <= 5'd0;
      ImmE        <= 32'd0;
      RegWriteE   <= 1'b0;
      RegDstE     <= 1'b0;
      ValidE      <= 1'b0;
      IllegalE    <= 1'b0;
    end else if (!StallE) begin
      ALUControlE <= alu_control_next;
      ALUSrcE     <= alu_src_next;
      ShamtSelE   <= shamt_sel_next;
      ShamtE      <= shamt_next;
      ImmE        <= imm_next;
      RegWriteE   <= reg_write_next;
      RegDstE     <= reg_dst_next;
      ValidE      <= 1'b1;
      IllegalE    <= illegal_next;
    end
  end

endmodule

// File: tb/tb_id_ex_alu_decode.sv
// Bench for id_ex_alu_decode: directed plan steps plus random traffic against a
// table-driven reference model of the decode and the pipeline-register rules.
module tb_id_ex_alu_decode;

  logic        clk = 1'b0;
  logic        reset, ValidD, StallE, FlushE;
  logic [31:0] InstrD;
  logic [3:0]  ALUControlE;
  logic        ALUSrcE, ShamtSelE, RegWriteE, RegDstE, ValidE, IllegalE;
  logic [4:0]  ShamtE;
  logic [31:0] ImmE;

  int checks = 0;
  int failures = 0;

  id_ex_alu_decode dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .ValidD(ValidD),
    .StallE(StallE), .FlushE(FlushE), .ALUControlE(ALUControlE),
    .ALUSrcE(ALUSrcE), .ShamtSelE(ShamtSelE), .ShamtE(ShamtE), .ImmE(ImmE),
    .RegWriteE(RegWriteE), .RegDstE(RegDstE), .ValidE(ValidE), .IllegalE(IllegalE)
  );

  always #5 clk = ~clk;

  // Lookup tables: R-type funct -> code, I-type op -> {code, sign-ext, regwrite, alusrc}.
  int r_code[int];
  int i_code[int];
  bit i_sext[int];
  bit i_rw[int];
  bit i_src[int];
  int legal_ops[12] = '{8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h23, 8'h2B, 8'h04, 8'h05};
  int legal_fns[16] = '{8'h21, 8'h20, 8'h23, 8'h22, 8'h2B, 8'h2A, 8'h00, 8'h04, 8'h02, 8'h06, 8'h03, 8'h07, 8'h24, 8'h25, 8'h26, 8'h27};

  logic [46:0] exp_reg;

  // Packed view {ctrl, alusrc, shsel, shamt, imm, rw, rd, valid, illegal}.
  function automatic logic [46:0] observed();
    return {ALUControlE, ALUSrcE, ShamtSelE, ShamtE, ImmE, RegWriteE, RegDstE, ValidE, IllegalE};
  endfunction

  function automatic logic [46:0] model(input logic [31:0] i);
    int op = int'(i[31:26]);
    int fn = int'(i[5:0]);
    logic [3:0] c = 4'd0;
    logic src = 0, ss = 0, rw = 0, rd = 0, ill = 0;
    logic [4:0] sh = 5'd0;
    logic [31:0] imm = 32'd0;
    if (op == 0) begin
      if (r_code.exists(fn)) begin
        c = 4'(r_code[fn]); rw = 1; rd = 1;
        if (fn == 0 || fn == 2 || fn == 3) begin ss = 1; sh = i[10:6]; end
      end else ill = 1;
    end else if (i_code.exists(op)) begin
      c = 4'(i_code[op]); src = i_src[op]; rw = i_rw[op];
      imm = i_sext[op] ? {{16{i[15]}}, i[15:0]} : {16'b0, i[15:0]};
      if (op == 8'h0F) begin ss = 1; sh = 5'd16; end
    end else ill = 1;
    return {c, src, ss, sh, imm, rw, rd, 1'b1, ill};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [31:0] instr, input logic v, input logic s,
                      input logic f, input logic r, input string tag);
    InstrD = instr; ValidD = v; StallE = s; FlushE = f; reset = r;
    @(posedge clk);
    if (r || f) exp_reg = '0;
    else if (!s) exp_reg = v ? model(instr) : '0;
    #1;
    $display("step %-10s instr=%08h v=%0d s=%0d f=%0d r=%0d -> ctrl=%b imm=%08h valid=%0d ill=%0d",
             tag, instr, v, s, f, r, ALUControlE, ImmE, ValidE, IllegalE);
    check(tag, 64'(observed()), 64'(exp_reg));
  endtask

  task automatic add_i(input int op, input int code, input bit sx, input bit rw, input bit src);
    i_code[op] = code; i_sext[op] = sx; i_rw[op] = rw; i_src[op] = src;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) r_code[legal_fns[k]] = k;
    add_i(8'h08, 1, 1, 1, 1);  add_i(8'h09, 0, 1, 1, 1);
    add_i(8'h0A, 5, 1, 1, 1);  add_i(8'h0B, 4, 1, 1, 1);
    add_i(8'h0C, 12, 0, 1, 1); add_i(8'h0D, 13, 0, 1, 1);
    add_i(8'h0E, 14, 0, 1, 1); add_i(8'h0F, 6, 0, 1, 1);
    add_i(8'h23, 0, 1, 1, 1);  add_i(8'h2B, 0, 1, 0, 1);
    add_i(8'h04, 2, 1, 0, 0);  add_i(8'h05, 2, 1, 0, 0);
    exp_reg = '0;
    InstrD = 32'h0; ValidD = 0; StallE = 0; FlushE = 0; reset = 1;

    step(32'h014B4820, 1, 0, 0, 1, "reset0");
    step(32'h014B4820, 1, 0, 0, 1, "reset1");
    check("reset_valid", 64'(ValidE), 64'd0);

    step(32'h2128FFFC, 1, 0, 0, 0, "addi");
    check("addi_ctrl", 64'(ALUControlE), 64'b0001);
    check("addi_imm", 64'(ImmE), 64'hFFFFFFFC);
    step(32'h3528F000, 1, 0, 0, 0, "ori");
    check("ori_imm", 64'(ImmE), 64'h0000F000);
    step(32'h3C081234, 1, 0, 0, 0, "lui");
    check("lui_shamt", 64'(ShamtE), 64'd16);
    step(32'h000940C3, 1, 0, 0, 0, "sra");
    check("sra_ctrl", 64'(ALUControlE), 64'b1010);
    step(32'h01494007, 1, 0, 0, 0, "srav");
    check("srav_shsel", 64'(ShamtSelE), 64'd0);

    step(32'h012A4022, 1, 0, 0, 0, "sub");
    for (int k = 0; k < 3; k++) begin
      step(32'h0, 1, 1, 0, 0, "stall");
      check("stall_ctrl", 64'(ALUControlE), 64'b0011);
    end
    step(32'h012A4022, 1, 1, 1, 0, "flushstall");
    check("flush_valid", 64'(ValidE), 64'd0);

    step(32'hFC000000, 1, 0, 0, 0, "illegal");
    check("ill_flag", 64'(IllegalE), 64'd1);
    step(32'hFC000000, 0, 0, 0, 0, "ill_bubble");
    step(32'h012A4022, 1, 0, 0, 0, "sub2");
    step(32'h0, 1, 1, 0, 0, "stall2");
    step(32'h0, 1, 1, 0, 1, "rst_stall");
    check("rst_stall_ctrl", 64'(ALUControlE), 64'd0);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      case ($urandom_range(0, 3))
        0: ins[5:0] = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'(legal_fns[$urandom_range(0, 15)]);
        1, 2: ins[31:26] = 6'(legal_ops[$urandom_range(0, 11)]);
        default: ;
      endcase
      if (ins[31:26] == 6'h00 && $urandom_range(0, 1) == 0) ins[31:26] = 6'h00;
      if ($urandom_range(0, 2) == 0) ins[31:26] = 6'h00;
      step(ins, $urandom_range(0, 7) != 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
